// File: rtl/gemm_isa_pkg.sv
// GEMM ISA shared definitions: default field widths, opcode encodings and the
// fetch controller state type.
package gemm_isa_pkg;

    localparam int DEF_INST_WIDTH    = 16;
    localparam int DEF_OPCODE_WIDTH  = 4;
    localparam int DEF_BUF_ID_WIDTH  = 2;
    localparam int DEF_MEM_LOC_WIDTH = 10;
    localparam int DEF_INST_DEPTH    = 1024;
    localparam int DEF_FIFO_DEPTH    = 2;

    localparam logic [DEF_OPCODE_WIDTH-1:0] OPC_LD       = 4'b0010;
    localparam logic [DEF_OPCODE_WIDTH-1:0] OPC_ST       = 4'b0011;
    localparam logic [DEF_OPCODE_WIDTH-1:0] OPC_GEMM     = 4'b0100;
    localparam logic [DEF_OPCODE_WIDTH-1:0] OPC_DRAINSYS = 4'b0101;
    localparam logic [DEF_OPCODE_WIDTH-1:0] OPC_HALT     = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/inst_mem.sv
// Instruction store: one write port, one synchronous read port with a
// single-cycle registered read latency.
module inst_mem #(
    parameter int  WIDTH = 16,
    parameter int  DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
)(
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Contents survive reset; only the fetch controller's state is cleared.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch controller: streams a loaded program out of local memory as
// decoded instructions over a ready/valid port until prog_len words or HALT.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; memory loads accepted
//   ST_RUN   | issuing reads while queue plus in-flight has room
//   ST_DRAIN | no more reads; waiting for queue and read pipe to empty
//   ST_DONE  | one-cycle done pulse, then back to idle
module inst_fetch
    import gemm_isa_pkg::*;
#(
    parameter int  INST_WIDTH    = DEF_INST_WIDTH,
    parameter int  OPCODE_WIDTH  = DEF_OPCODE_WIDTH,
    parameter int  BUF_ID_WIDTH  = DEF_BUF_ID_WIDTH,
    parameter int  MEM_LOC_WIDTH = DEF_MEM_LOC_WIDTH,
    parameter int  INST_DEPTH    = DEF_INST_DEPTH,
    parameter int  FIFO_DEPTH    = DEF_FIFO_DEPTH,
    localparam int AW            = $clog2(INST_DEPTH)
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_en,
    input  logic [AW-1:0]            load_addr,
    input  logic [INST_WIDTH-1:0]    load_data,
    input  logic                     start,
    input  logic [AW:0]              prog_len,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_WIDTH-1:0]  opcode,
    output logic [BUF_ID_WIDTH-1:0]  buf_id,
    output logic [MEM_LOC_WIDTH-1:0] mem_loc,
    output logic                     busy,
    output logic                     done,
    output logic                     err_opcode
);

    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam int          CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW:0] DEPTH_LEN = (AW+1)'(INST_DEPTH);
    localparam logic [AW-1:0] LAST_PC = AW'(INST_DEPTH - 1);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [AW-1:0]         r_pc;
    logic [AW:0]           r_remain;
    logic                  r_rd_pend;
    logic                  r_err;

    logic [INST_WIDTH-1:0] r_fifo [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic [INST_WIDTH-1:0]   w_rd_data;
    logic [INST_WIDTH-1:0]   w_head;
    logic [OPCODE_WIDTH-1:0] w_rd_opc;
    logic                    w_rd_halt;
    logic                    w_rd_legal;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_issue;
    logic                    w_accept;
    logic                    w_mem_we;
    logic [AW:0]             w_len_clamped;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_rd_opc   = w_rd_data[INST_WIDTH-1 -: OPCODE_WIDTH];
    assign w_rd_halt  = &w_rd_opc;
    assign w_rd_legal = (w_rd_opc == OPCODE_WIDTH'(OPC_LD))   ||
                        (w_rd_opc == OPCODE_WIDTH'(OPC_ST))   ||
                        (w_rd_opc == OPCODE_WIDTH'(OPC_GEMM)) ||
                        (w_rd_opc == OPCODE_WIDTH'(OPC_DRAINSYS));

    assign out_valid     = (r_count != '0);
    assign w_pop         = out_valid && out_ready;
    assign w_push        = r_rd_pend && !w_rd_halt;
    assign w_len_clamped = (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
    assign w_accept      = (r_state == ST_IDLE) && start && (prog_len != '0);
    assign w_mem_we      = load_en && (r_state == ST_IDLE);

    inst_mem #(
        .WIDTH (INST_WIDTH),
        .DEPTH (INST_DEPTH)
    ) u_inst_mem (
        .clk       (clk),
        .i_wr_en   (w_mem_we),
        .i_wr_addr (load_addr),
        .i_wr_data (load_data),
        .i_rd_en   (w_issue),
        .i_rd_addr (r_pc),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The slot credit counts this cycle's pop so a full-rate consumer never sees a bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = (prog_len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (r_rd_pend && w_rd_halt) begin
                    w_state_nxt = ST_DRAIN;
                end else if (r_remain == '0) begin
                    w_state_nxt = ST_DRAIN;
                end else if ((int'(r_count) + int'(r_rd_pend) - int'(w_pop)) < FIFO_DEPTH) begin
                    w_issue = 1'b1;
                    if (r_remain == (AW+1)'(1)) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if ((r_count == '0) && !r_rd_pend) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= '0;
            r_remain  <= '0;
            r_rd_pend <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_rd_pend <= w_issue;
            if (w_accept) begin
                r_pc     <= '0;
                r_remain <= w_len_clamped;
                r_err    <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_remain <= r_remain - 1'b1;
                    if (r_pc != LAST_PC) begin
                        r_pc <= r_pc + 1'b1;
                    end
                end
                if (w_push && !w_rd_legal) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_rd_data;
                r_wr_ptr         <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head     = r_fifo[r_rd_ptr];
    assign opcode     = w_head[INST_WIDTH-1 -: OPCODE_WIDTH];
    assign buf_id     = w_head[INST_WIDTH-OPCODE_WIDTH-1 -: BUF_ID_WIDTH];
    assign mem_loc    = w_head[MEM_LOC_WIDTH-1:0];
    assign err_opcode = r_err;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed and randomized programs checked against a
// program-level reference model (expected instruction stream and error flag).
module tb_inst_fetch;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en;
    logic [9:0]  load_addr;
    logic [15:0] load_data;
    logic        start;
    logic [10:0] prog_len;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  opcode;
    logic [1:0]  buf_id;
    logic [9:0]  mem_loc;
    logic        busy;
    logic        done;
    logic        err_opcode;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] model_mem [DEPTH];
    logic        model_err = 1'b0;

    inst_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .prog_len   (prog_len),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .opcode     (opcode),
        .buf_id     (buf_id),
        .mem_loc    (mem_loc),
        .busy       (busy),
        .done       (done),
        .err_opcode (err_opcode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [3:0] op);
        return op inside {4'h2, 4'h3, 4'h4, 4'h5};
    endfunction

    function automatic logic [15:0] rand_word(input bit allow_odd);
        logic [3:0]  op;
        logic [31:0] r;
        int          sel;
        r   = $urandom;
        sel = allow_odd ? $urandom_range(0, 9) : 0;
        if (sel < 7)       op = 4'(2 + $urandom_range(0, 3));
        else if (sel == 7) op = 4'hF;
        else               op = 4'($urandom_range(6, 14));
        return {op, r[11:0]};
    endfunction

    function automatic logic ready_for(input int mode, input int i);
        case (mode)
            0:       return 1'b1;
            1:       return (i % 3) == 0;
            2:       return 1'($urandom_range(0, 1));
            default: return i >= 8;
        endcase
    endfunction

    task automatic load_word(input int a, input logic [15:0] d);
        logic [31:0] av;
        av        = a;
        load_en   = 1'b1;
        load_addr = av[9:0];
        load_data = d;
        @(posedge clk); #1;
        load_en   = 1'b0;
        model_mem[a] = d;
    endtask

    // Called and returns one time unit after a rising edge.
    task automatic run_prog(input int len, input int mode, input bit check_timing);
        logic [15:0] exp_q[$];
        logic [15:0] fields;
        logic [15:0] held;
        logic [31:0] lv;
        int n, got, idx, first_v, last_x, done_idx, done_cnt;
        bit stalled;
        n = (len > DEPTH) ? DEPTH : len;
        got = 0; idx = 0; first_v = -1; last_x = -1; done_idx = -1; done_cnt = 0;
        stalled = 0; held = '0;
        if (len > 0) begin
            model_err = 1'b0;
            for (int a = 0; a < n; a++) begin
                if (model_mem[a][15:12] == 4'hF) break;
                exp_q.push_back(model_mem[a]);
                if (!legal(model_mem[a][15:12])) model_err = 1'b1;
            end
        end
        lv        = len;
        start     = 1'b1;
        prog_len  = lv[10:0];
        out_ready = ready_for(mode, 0);
        @(posedge clk); #1;
        start = 1'b0;
        while (done_cnt == 0 && idx < 4 * n + 60) begin
            @(negedge clk);
            fields = {opcode, buf_id, mem_loc};
            if (stalled) begin
                chk("valid_held", 32'(out_valid), 32'd1);
                chk("fields_stable", 32'(fields), 32'(held));
            end
            stalled = 0;
            if (out_valid) begin
                if (first_v < 0) first_v = idx;
                if (out_ready) begin
                    if (got < exp_q.size()) chk($sformatf("xfer%0d", got), 32'(fields), 32'(exp_q[got]));
                    if (check_timing && last_x >= 0) chk("back_to_back", idx - last_x, 32'd1);
                    last_x = idx;
                    got++;
                end else begin
                    stalled = 1;
                    held    = fields;
                end
            end
            if (done) begin
                done_cnt++;
                done_idx = idx;
            end
            @(posedge clk); #1;
            start   = 1'b0;
            load_en = 1'b0;
            if (mode == 3 && idx == 2) begin
                start     = 1'b1;
                prog_len  = 11'd1;
                load_en   = 1'b1;
                load_addr = 10'd2;
                load_data = 16'h2ABC;
            end
            idx++;
            out_ready = ready_for(mode, idx);
        end
        chk("done_seen", done_cnt, 32'd1);
        chk("xfer_count", got, exp_q.size());
        chk("err_opcode", 32'(err_opcode), 32'(model_err));
        if (check_timing) chk("first_valid_latency", first_v, (exp_q.size() > 0) ? 32'd2 : 32'hFFFF_FFFF);
        if (check_timing && len == 0) chk("done_latency_len0", done_idx, 32'd0);
        if (done_idx >= 0 && last_x >= 0) chk("done_after_last", 32'(done_idx > last_x), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, mode;
        rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; prog_len = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_opcode), 32'd0);
        chk("rst_fields", 32'({opcode, buf_id, mem_loc}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Basic four-instruction program, full rate then stalling consumer
        load_word(0, {4'h2, 2'd1, 10'h03A});
        load_word(1, {4'h3, 2'd2, 10'h155});
        load_word(2, {4'h4, 2'd3, 10'h2AA});
        load_word(3, {4'h5, 2'd0, 10'h3FF});
        run_prog(4, 0, 1);
        run_prog(4, 1, 0);

        // HALT in the middle stops the stream
        load_word(0, {4'h2, 2'd2, 10'h011});
        load_word(1, 16'hF000);
        load_word(2, {4'h3, 2'd1, 10'h022});
        run_prog(3, 0, 1);

        // Illegal opcode is forwarded and flagged
        load_word(0, 16'h9000);
        run_prog(1, 0, 1);
        repeat (5) @(posedge clk); #1;
        chk("err_sticky", 32'(err_opcode), 32'd1);

        // Empty program
        run_prog(0, 0, 1);

        // start and load_en during RUN are ignored
        for (int a = 0; a < 6; a++) load_word(a, rand_word(0));
        run_prog(6, 3, 0);
        run_prog(6, 2, 0);

        // Reset with a full queue and a stalled consumer
        start = 1'b1; prog_len = 11'd4; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk); #1;
        chk("full_before_reset", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_fields", 32'({opcode, buf_id, mem_loc}), 32'd0);
        #2 rst_n = 1'b1;
        model_err = 1'b0;
        @(posedge clk); #1;
        run_prog(4, 0, 1);

        // Randomized programs with mixed opcodes and consumer behaviour
        for (int it = 0; it < 8; it++) begin
            for (int a = 0; a < 16; a++) load_word(a, rand_word(1));
            len  = $urandom_range(1, 16);
            mode = $urandom_range(0, 2);
            run_prog(len, mode, mode == 0);
        end

        // Program longer than memory stops at the last word
        for (int a = 0; a < DEPTH; a++) load_word(a, rand_word(0));
        run_prog(1030, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
